// File: rtl/lib_uart.sv
// rtl/lib_uart.sv - shared UART state encoding and TX FIFO sizing
package lib_uart;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} UART_STATE;
    localparam int UART_TX_FIFO_DEPTH = 4;
endpackage

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - uart_rx synchroniser, RX FSM and shift register
// valid pulses for one cycle at a good stop bit, with rx_byte holding the frame.
module uart_rx_core
    import lib_uart::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 valid
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF     = CW'(CLKS_PER_BIT / 2);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    UART_STATE            state, state_next;
    logic [CW-1:0]        cnt, cnt_next;
    logic [BW-1:0]        bit_cnt, bit_cnt_next;
    logic [DATA_BITS-1:0] shreg, shreg_next;
    logic                 sync1, rxs, rxs_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            sync1   <= uart_rx;
            rxs     <= sync1;
            rxs_d   <= rxs;
            state   <= state_next;
            cnt     <= cnt_next;
            bit_cnt <= bit_cnt_next;
            shreg   <= shreg_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt + 1'b1;
        bit_cnt_next = bit_cnt;
        shreg_next   = shreg;
        valid        = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (rxs_d && !rxs) state_next = START;
            end
            START: if (cnt == HALF) begin
                cnt_next     = '0;
                bit_cnt_next = '0;
                state_next   = rxs ? IDLE : DATA;
            end
            DATA: if (cnt == LAST) begin
                cnt_next     = '0;
                shreg_next   = {rxs, shreg[DATA_BITS-1:1]};
                bit_cnt_next = bit_cnt + 1'b1;
                if (bit_cnt == LAST_BIT) state_next = STOP;
            end
            STOP: if (cnt == LAST) begin
                // a low stop bit is a framing error: the byte is simply not flagged
                cnt_next   = '0;
                valid      = rxs;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign rx_byte = shreg;
endmodule

// File: rtl/uart_io.sv
// rtl/uart_io.sv - CPU-facing UART: TX FSM, r_data/intr register, RX core
// UART_IO_TX_FIFO_EN adds a 4-entry TX FIFO in front of the TX FSM.
module uart_io
    import lib_uart::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 w_req,
    input  logic [DATA_BITS-1:0] w_data,
    output logic                 w_busy,
    output logic [DATA_BITS-1:0] r_data,
    output logic                 intr,
    input  logic                 ack,
    output logic                 uart_tx,
    input  logic                 uart_rx
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    UART_STATE            tx_state, tx_state_next;
    logic [CW-1:0]        tx_cnt, tx_cnt_next;
    logic [BW-1:0]        tx_bit, tx_bit_next;
    logic [DATA_BITS-1:0] tx_sh, tx_sh_next;
    logic                 tx_q, tx_next;
    logic                 src_valid;
    logic [DATA_BITS-1:0] src_data;

`ifdef UART_IO_TX_FIFO_EN
    localparam int PW = $clog2(UART_TX_FIFO_DEPTH);
    logic [DATA_BITS-1:0] fifo_mem [UART_TX_FIFO_DEPTH];
    logic [PW:0]          wr_ptr, rd_ptr, rd_next;
    logic                 fifo_full, fifo_empty, push, pop;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign push       = w_req && !fifo_full;
    assign rd_next    = rd_ptr + 1'b1;
    // The in-flight byte keeps its slot until its stop bit ends, then the next head follows.
    assign pop        = (tx_state == STOP) && (tx_cnt == LAST);
    assign src_valid  = (tx_state == IDLE) ? !fifo_empty : (rd_next != wr_ptr);
    assign src_data   = (tx_state == IDLE) ? fifo_mem[rd_ptr[PW-1:0]] : fifo_mem[rd_next[PW-1:0]];
    assign w_busy     = fifo_full;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[PW-1:0]] <= w_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_next;
        end
    end
`else
    assign src_valid = w_req && (tx_state == IDLE);
    assign src_data  = w_data;
    assign w_busy    = (tx_state != IDLE);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            tx_q     <= 1'b1;
        end else begin
            tx_state <= tx_state_next;
            tx_cnt   <= tx_cnt_next;
            tx_bit   <= tx_bit_next;
            tx_sh    <= tx_sh_next;
            tx_q     <= tx_next;
        end
    end

    always_comb begin
        tx_state_next = tx_state;
        tx_cnt_next   = tx_cnt + 1'b1;
        tx_bit_next   = tx_bit;
        tx_sh_next    = tx_sh;
        case (tx_state)
            IDLE: begin
                tx_cnt_next = '0;
                if (src_valid) begin
                    tx_state_next = START;
                    tx_sh_next    = src_data;
                end
            end
            START: if (tx_cnt == LAST) begin
                tx_cnt_next   = '0;
                tx_bit_next   = '0;
                tx_state_next = DATA;
            end
            DATA: if (tx_cnt == LAST) begin
                tx_cnt_next = '0;
                tx_sh_next  = tx_sh >> 1;
                tx_bit_next = tx_bit + 1'b1;
                if (tx_bit == LAST_BIT) tx_state_next = STOP;
            end
            STOP: if (tx_cnt == LAST) begin
                tx_cnt_next = '0;
                if (src_valid) begin
                    tx_state_next = START;
                    tx_sh_next    = src_data;
                end else begin
                    tx_state_next = IDLE;
                end
            end
            default: tx_state_next = IDLE;
        endcase
        // registered pin: the line level follows the state being entered
        tx_next = 1'b1;
        if (tx_state_next == START)     tx_next = 1'b0;
        else if (tx_state_next == DATA) tx_next = tx_sh_next[0];
    end

    assign uart_tx = tx_q;

    logic [DATA_BITS-1:0] rx_byte;
    logic                 rx_valid;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .DATA_BITS   (DATA_BITS)
    ) u_rx (
        .clk    (clk),
        .rst_n  (rst_n),
        .uart_rx(uart_rx),
        .rx_byte(rx_byte),
        .valid  (rx_valid)
    );

    // a new byte outranks a simultaneous ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            intr   <= 1'b0;
        end else if (rx_valid) begin
            r_data <= rx_byte;
            intr   <= 1'b1;
        end else if (ack) begin
            intr   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_io.sv
// tb/tb_uart_io.sv - scoreboard bench for uart_io at CLKS_PER_BIT=4
`timescale 1ns/1ps
module tb_uart_io;
    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       w_req = 1'b0;
    logic       ack = 1'b0;
    logic       rx_drv = 1'b1;
    logic       loop = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic       w_busy, intr, uart_tx;
    logic [7:0] r_data;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         busy_cnt;
    logic       found;
    logic       chk_gap = 1'b0;
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];

    uart_io #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .w_req  (w_req),
        .w_data (w_data),
        .w_busy (w_busy),
        .r_data (r_data),
        .intr   (intr),
        .ack    (ack),
        .uart_tx(uart_tx),
        .uart_rx(loop ? uart_tx : rx_drv)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rx_drv = bits[i];
            repeat (3) @(negedge clk);
        end
        @(negedge clk);
        rx_drv = 1'b1;
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    initial begin : rx_mon
        logic       pi;
        logic [7:0] pr;
        logic [7:0] e;
        pi = 1'b0;
        pr = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n && intr && (!pi || r_data != pr)) begin
                if (rx_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected actual=%0h required=none", r_data);
                end else begin
                    e = rx_exp.pop_front();
                    check("rx_byte", r_data, e);
                end
            end
            pi = intr;
            pr = r_data;
        end
    end

    initial begin : tx_mon
        logic [9:0] got;
        logic       stable, aborted, gap_armed;
        int         last_end;
        logic [7:0] e;
        gap_armed = 1'b0;
        last_end  = 0;
        forever begin
            @(negedge clk);
            if (rst_n && uart_tx === 1'b0) begin
                if (gap_armed) check("tx_gap", cyc - last_end, 1);
                got = 10'b0;
                stable = 1'b1;
                aborted = 1'b0;
                for (int k = 1; k < 40; k++) begin
                    @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (k % 4 == 0) got[k/4] = uart_tx;
                    else if (uart_tx !== got[k/4]) stable = 1'b0;
                end
                if (!aborted) begin
                    last_end  = cyc;
                    gap_armed = chk_gap;
                    if (tx_exp.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_unexpected actual=%0h required=none", got[8:1]);
                    end else begin
                        e = tx_exp.pop_front();
                        check("tx_frame", {21'b0, stable, got}, {21'b0, 1'b1, 1'b1, e, 1'b0});
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_uart_tx", uart_tx, 1);
        check("rst_w_busy", w_busy, 0);
        check("rst_r_data", r_data, 8'h00);
        check("rst_intr", intr, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // TX 0xA5; a 0x77 write during the frame must be dropped
        w_data = 8'hA5;
        w_req  = 1'b1;
        tx_exp.push_back(8'hA5);
        busy_cnt = 0;
        for (int k = 1; k <= 41; k++) begin
            @(negedge clk);
            if (k == 1) w_req = 1'b0;
`ifndef UART_IO_TX_FIFO_EN
            if (k == 10) begin
                w_data = 8'h77;
                w_req  = 1'b1;
            end
            if (k == 11) w_req = 1'b0;
            if (k == 1)  check("tx_busy_first", w_busy, 1);
            if (k == 41) check("tx_busy_release", w_busy, 0);
            if (k <= 40 && w_busy) busy_cnt++;
`endif
        end
`ifndef UART_IO_TX_FIFO_EN
        check("tx_busy_cycles", busy_cnt, 40);
`endif
        repeat (10) @(negedge clk);

        // RX 0x3C, ack five cycles after intr
        rx_exp.push_back(8'h3C);
        rx_frame(8'h3C, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (intr) found = 1'b1;
        end
        check("rx_intr_rise", found, 1);
        repeat (4) @(negedge clk);
        check("intr_hold", intr, 1);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("intr_cleared", intr, 0);

        // glitch: false start
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (2) @(negedge clk);
        rx_drv = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_no_intr", intr, 0);

        // framing error then a good frame
        rx_frame(8'hFF, 1'b0);
        repeat (10) @(negedge clk);
        check("frame_err_r_data", r_data, 8'h3C);
        check("frame_err_intr", intr, 0);
        rx_exp.push_back(8'h11);
        rx_frame(8'h11, 1'b1);
        repeat (5) @(negedge clk);
        check("rx11_intr", intr, 1);

        // ack lands on the latch cycle of 0x55: set wins
        rx_exp.push_back(8'h55);
        fork
            rx_frame(8'h55, 1'b1);
            begin
                repeat (42) @(negedge clk);
                ack = 1'b1;
                @(negedge clk);
                ack = 1'b0;
                check("ack_collision_intr", intr, 1);
                check("ack_collision_r_data", r_data, 8'h55);
            end
        join
        ack_pulse();
        check("intr_cleared2", intr, 0);
        ack_pulse();
        check("ack_idle_noeffect", intr, 0);

        // loopback
        loop = 1'b1;
        repeat (2) @(negedge clk);
        w_data = 8'h5A;
        w_req  = 1'b1;
        tx_exp.push_back(8'h5A);
        rx_exp.push_back(8'h5A);
        @(negedge clk);
        w_req = 1'b0;
        repeat (60) @(negedge clk);
        check("loop_intr", intr, 1);
        ack_pulse();
        loop = 1'b0;
        repeat (5) @(negedge clk);

        // reset mid-frame on both directions
        w_data = 8'h99;
        w_req  = 1'b1;
        @(negedge clk);
        w_req  = 1'b0;
        rx_drv = 1'b0;
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_uart_tx", uart_tx, 1);
        check("midrst_w_busy", w_busy, 0);
        check("midrst_r_data", r_data, 8'h00);
        check("midrst_intr", intr, 0);
        rx_drv = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("midrst_no_partial", intr, 0);

`ifdef UART_IO_TX_FIFO_EN
        chk_gap = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            w_data = 8'(i);
            w_req  = 1'b1;
            if (i <= 4) tx_exp.push_back(8'(i));
            @(negedge clk);
            if (i == 4) check("fifo_full_busy", w_busy, 1);
        end
        w_req = 1'b0;
        repeat (200) @(negedge clk);
        chk_gap = 1'b0;
`endif

        for (int i = 0; i < 200 && (tx_exp.size() != 0 || rx_exp.size() != 0); i++)
            @(negedge clk);
        check("tx_queue_empty", tx_exp.size(), 0);
        check("rx_queue_empty", rx_exp.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
